ctrl_reg_master: RTL and testbench
==================================

# ctrl_reg_master

Command engine on the clk_b side that drives the control register file's write/read port from a byte stream. It parses host command frames (already deserialized into bytes by the link receiver) and issues single-cycle register writes. For reads, it selects the register, waits out the register file's pipeline latency, and returns the 16-bit value as two response bytes. It is the initiator for CDC_data / nr_Rejestru / wr_Rej and the consumer of Rej_out.

## Interface
Parameters:
- RD_WAIT, 4: cycles from nr_Rejestru change to Rej_out sample (min 4).
- TIMEOUT_CYCLES, 1000000: inter-byte timeout. Used only with CTRL_MASTER_TIMEOUT_EN.

Ports:
- clk_b, in, 1: clock.
- rst_n, in, 1: reset; asynchronous, active-low.
- rx_data, in, 8: command/data byte.
- rx_valid, in, 1: rx_data valid.
- rx_ready, out, 1: byte accepted when rx_valid && rx_ready.
- tx_data, out, 8: response byte.
- tx_valid, out, 1: response byte valid.
- tx_ready, in, 1: response byte consumed when tx_valid && tx_ready.
- CDC_data, out, 16: write data to register file.
- nr_Rejestru, out, 3: register address.
- wr_Rej, out, 1: one-cycle write strobe.
- Rej_out, in, 16: registered read data from register file.
- busy, out, 1: high in any state except IDLE.
- err_cmd, out, 1: one-cycle pulse on malformed command or timeout.

## Operation
- Command byte: bit7 = R/W (1 = write, 0 = read), bits[6:3] must be 0, bits[2:0] = address.
- Write frame: cmd, data[15:8], data[7:0]. Read frame: cmd only. Read response: Rej_out[15:8], then Rej_out[7:0].
- A command byte with bits[6:3] != 0: byte dropped, err_cmd pulses, state stays IDLE.
- Addresses 5–7 are legal. Writes to them, and to addresses 1–2, are forwarded; the register file ignores them. Reads from 5–7 return 0x0000.
- FSM states:
  - IDLE: accept cmd. Write → WR_HI; read → RD_WAIT with nr_Rejestru <= addr and counter cleared.
  - WR_HI: accept byte into CDC_data[15:8] → WR_LO.
  - WR_LO: accept byte into CDC_data[7:0] → WR_ISSUE.
  - WR_ISSUE: wr_Rej = 1 for this cycle, nr_Rejestru = latched addr → IDLE.
  - RD_WAIT: count RD_WAIT cycles, then capture Rej_out into a 16-bit hold register → TX_HI.
  - TX_HI: tx_data = hold[15:8], tx_valid = 1 until handshake → TX_LO.
  - TX_LO: tx_data = hold[7:0], tx_valid = 1 until handshake → IDLE.
- rx_ready = 1 only in IDLE, WR_HI and WR_LO. tx_valid = 1 only in TX_HI and TX_LO.
- tx_data is stable while tx_valid && !tx_ready.
- nr_Rejestru and CDC_data hold their last values outside transactions. No change except on a new command or data byte.
- Reads never assert wr_Rej.

## Timing
- Reset values: rx_ready 0, tx_valid 0, tx_data 0x00, CDC_data 0x0000, nr_Rejestru 0, wr_Rej 0, busy 0, err_cmd 0, state IDLE. rx_ready rises on the first clk_b edge after reset release.
- Write: wr_Rej asserts the cycle after the data[7:0] handshake. The next cmd can be accepted the cycle after that, so there is one idle cycle between frames.
- Read: capture happens RD_WAIT cycles after nr_Rejestru updates. First tx_valid is the following cycle.
- RD_WAIT ≥ 4 covers the worst case of a write to addr 0 immediately followed by a read of addr 0. The register file needs 3 cycles from the wr_Rej cycle to reflect the write on Rej_out.
- Back-to-back rx bytes every cycle are accepted with no stall in the write path.
- Reset mid-frame aborts everything immediately: wr_Rej and tx_valid drop asynchronously, no partial write, partially sent response discarded.

## Configuration
- CTRL_MASTER_TIMEOUT_EN defined: in WR_HI/WR_LO, an idle counter runs while no rx handshake occurs. It reloads on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: → IDLE, err_cmd pulses, no wr_Rej.
- CTRL_MASTER_TIMEOUT_EN undefined: no counter, no timeout logic. WR_HI/WR_LO wait indefinitely.

## Structure
- Shared package ctrl_pkg:
  - state enum ctrl_master_state_t.
  - Command field constants: CMD_RW_BIT = 7, CMD_ADDR_W = 3.
  - Register address constants: REG_START = 0, REG_DONE = 1, REG_PRACUJE = 2, REG_ILE_WSP = 3, REG_ILE_PROBEK = 4.
- One sub-module, ctrl_timeout_cnt (load/count/expire), instantiated only under CTRL_MASTER_TIMEOUT_EN.

## Test plan
- Write ILE_WSP: bytes 0x83, 0x00, 0x2A → single wr_Rej pulse with nr_Rejestru = 3, CDC_data = 0x002A. Then read 0x03 → tx bytes 0x00, 0x2A.
- Write ILE_PROBEK: bytes 0x84, 0x3F, 0xFF with rx_valid every cycle → no stall. Read 0x04 → 0x3F, 0xFF.
- Write START then immediate read: 0x80, 0x00, 0x01, 0x00 back-to-back → response 0x00, 0x01 (latency margin).
- Bad command: byte 0x48 → err_cmd pulse, no wr_Rej, next byte 0x01 handled as a read of addr 1 (returns DONE).
- tx backpressure: read 0x02 with tx_ready low 10 cycles → tx_data held at high byte, correct order after release. Plus rst_n pulse during TX_LO → all outputs at reset values.
- With CTRL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: send 0x83, 0x12, then stall 16 cycles → err_cmd, no wr_Rej, a new 0x03 read works.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control register master: FSM state
// encoding, command byte layout and register file addresses.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_WR_ISSUE,
    ST_RD_WAIT,
    ST_TX_HI,
    ST_TX_LO
  } ctrl_master_state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 3;

  localparam logic [CMD_ADDR_W-1:0] REG_START      = 3'd0;
  localparam logic [CMD_ADDR_W-1:0] REG_DONE       = 3'd1;
  localparam logic [CMD_ADDR_W-1:0] REG_PRACUJE    = 3'd2;
  localparam logic [CMD_ADDR_W-1:0] REG_ILE_WSP    = 3'd3;
  localparam logic [CMD_ADDR_W-1:0] REG_ILE_PROBEK = 3'd4;

  // Bits between the R/W flag and the address field are reserved and must be zero.
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd[CMD_RW_BIT-1:CMD_ADDR_W] == '0);
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Inter-byte idle counter: cleared on load or when disabled, counts while
// enabled, and flags expiry on the cycle that completes TIMEOUT_CYCLES idle cycles.
module ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_b,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load || !count_en) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = count_en && !load && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ctrl_reg_master.sv
// Byte-stream command engine driving the control register file port.
// Optional inter-byte timeout in the write path: define CTRL_MASTER_TIMEOUT_EN.
module ctrl_reg_master
  import ctrl_pkg::*;
#(
  parameter int RD_WAIT        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] CDC_data,
  output logic [2:0]  nr_Rejestru,
  output logic        wr_Rej,
  input  logic [15:0] Rej_out,
  output logic        busy,
  output logic        err_cmd
);

  localparam int RD_CNT_W = $clog2(RD_WAIT) + 1;

  ctrl_master_state_t      state_reg, state_next;
  logic                    ready_en_reg;
  logic [CMD_ADDR_W-1:0]   nr_reg;
  logic [15:0]             hold_reg;
  logic [RD_CNT_W-1:0]     rd_cnt_reg;
  logic                    err_cmd_reg;
  logic                    rx_hs;
  logic                    cmd_ok;
  logic                    cmd_accept;
  logic                    rd_done;
  logic                    timeout_hit;

  assign rx_hs      = rx_valid && rx_ready;
  assign cmd_ok     = cmd_is_valid(rx_data);
  assign cmd_accept = (state_reg == ST_IDLE) && rx_hs && cmd_ok;
  assign rd_done    = (rd_cnt_reg == RD_CNT_W'(RD_WAIT - 1));

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_accept) begin
          state_next = rx_data[CMD_RW_BIT] ? ST_WR_HI : ST_RD_WAIT;
        end
      end
      ST_WR_HI: begin
        if (timeout_hit)  state_next = ST_IDLE;
        else if (rx_hs)   state_next = ST_WR_LO;
      end
      ST_WR_LO: begin
        if (timeout_hit)  state_next = ST_IDLE;
        else if (rx_hs)   state_next = ST_WR_ISSUE;
      end
      ST_WR_ISSUE: state_next = ST_IDLE;
      ST_RD_WAIT:  if (rd_done) state_next = ST_TX_HI;
      ST_TX_HI:    if (tx_ready) state_next = ST_TX_LO;
      ST_TX_LO:    if (tx_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wr_Rej   = 1'b0;
    busy     = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE, ST_WR_HI, ST_WR_LO: rx_ready = ready_en_reg;
      ST_WR_ISSUE: wr_Rej = 1'b1;
      ST_TX_HI: begin
        tx_valid = 1'b1;
        tx_data  = hold_reg[15:8];
      end
      ST_TX_LO: begin
        tx_valid = 1'b1;
        tx_data  = hold_reg[7:0];
      end
      default: ;
    endcase
  end

  // ready_en_reg keeps rx_ready low until the first edge after reset release.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      nr_reg       <= '0;
      hold_reg     <= '0;
      rd_cnt_reg   <= '0;
      err_cmd_reg  <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      err_cmd_reg  <= ((state_reg == ST_IDLE) && rx_hs && !cmd_ok) || timeout_hit;
      if (cmd_accept) begin
        nr_reg <= rx_data[CMD_ADDR_W-1:0];
      end
      if (state_reg == ST_RD_WAIT) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        if (rd_done) begin
          hold_reg <= Rej_out;
        end
      end else begin
        rd_cnt_reg <= '0;
      end
    end
  end

  // Lane 1 captures the high data byte in WR_HI, lane 0 the low byte in WR_LO.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam ctrl_master_state_t LANE_ST = (gi == 1) ? ST_WR_HI : ST_WR_LO;
      logic [7:0] lane_reg;
      always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= 8'h00;
        end else if (rx_hs && (state_reg == LANE_ST)) begin
          lane_reg <= rx_data;
        end
      end
      assign CDC_data[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  assign nr_Rejestru = nr_reg;
  assign err_cmd     = err_cmd_reg;

`ifdef CTRL_MASTER_TIMEOUT_EN
  ctrl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_b    (clk_b),
    .rst_n    (rst_n),
    .load     (rx_hs),
    .count_en ((state_reg == ST_WR_HI) || (state_reg == ST_WR_LO)),
    .expire   (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_reg_master.sv
// Self-checking bench for ctrl_reg_master: vector table of write/read frames,
// scoreboards for register writes and response bytes, plus hand-written corner cases.
module tb_ctrl_reg_master;

  localparam int          TB_RD_WAIT  = 4;
  localparam int          TB_TIMEOUT  = 16;
  localparam logic [15:0] DONE_VAL    = 16'h0001;
  localparam logic [15:0] PRACUJE_VAL = 16'hC35A;

  logic        clk_b = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] CDC_data;
  logic [2:0]  nr_Rejestru;
  logic        wr_Rej;
  logic [15:0] Rej_out = 16'h0000;
  logic        busy;
  logic        err_cmd;

  int errors = 0;
  int checks = 0;

  logic [18:0] wr_q[$];
  logic [7:0]  tx_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  always #5 clk_b = ~clk_b;

  ctrl_reg_master #(
    .RD_WAIT       (TB_RD_WAIT),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk_b       (clk_b),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .CDC_data    (CDC_data),
    .nr_Rejestru (nr_Rejestru),
    .wr_Rej      (wr_Rej),
    .Rej_out     (Rej_out),
    .busy        (busy),
    .err_cmd     (err_cmd)
  );

  // Register file model: writable 0/3/4, status at 1/2, 5-7 read as zero,
  // two-stage read pipeline so a write shows on Rej_out 3 cycles after wr_Rej.
  logic [15:0] rf0 = 16'h0000;
  logic [15:0] rf3 = 16'h0000;
  logic [15:0] rf4 = 16'h0000;
  logic [15:0] rf_mux;
  logic [15:0] rf_stage = 16'h0000;

  always_comb begin
    rf_mux = 16'h0000;
    case (nr_Rejestru)
      3'd0: rf_mux = rf0;
      3'd1: rf_mux = DONE_VAL;
      3'd2: rf_mux = PRACUJE_VAL;
      3'd3: rf_mux = rf3;
      3'd4: rf_mux = rf4;
      default: rf_mux = 16'h0000;
    endcase
  end

  always @(posedge clk_b) begin
    if (wr_Rej) begin
      case (nr_Rejestru)
        3'd0: rf0 <= CDC_data;
        3'd3: rf3 <= CDC_data;
        3'd4: rf4 <= CDC_data;
        default: ;
      endcase
    end
    rf_stage <= rf_mux;
    Rej_out  <= rf_stage;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitors sample just after the falling edge, well away from the active edge.
  initial begin
    forever begin
      @(negedge clk_b);
      #1;
      if (rst_n && wr_Rej) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", nr_Rejestru, CDC_data);
        end else begin
          chk("wr_addr_data", {nr_Rejestru, CDC_data}, wr_q.pop_front());
        end
      end
      if (rst_n && tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %h expected none", tx_data);
        end else begin
          chk("tx_byte", tx_data, tx_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int stall);
    stall    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && stall < 200) begin
      @(negedge clk_b);
      stall++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_wait: got rx_ready 0 expected 1 for byte %h", b);
    end
    @(negedge clk_b);
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [2:0] addr, input logic [15:0] data);
    int n0, n1, n2;
    wr_q.push_back({addr, data});
    send_byte({1'b1, 4'b0000, addr}, n0);
    send_byte(data[15:8], n1);
    send_byte(data[7:0], n2);
    chk("wr_data_no_stall", n1 + n2, 0);
    chk("wr_strobe_timing", wr_Rej, 1'b1);
  endtask

  task automatic send_read_cmd(input logic [2:0] addr, input logic [15:0] exp);
    int n, k;
    tx_q.push_back(exp[15:8]);
    tx_q.push_back(exp[7:0]);
    send_byte({1'b0, 4'b0000, addr}, n);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk_b);
      k++;
    end
    chk("rd_latency", k, TB_RD_WAIT);
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 100) begin
      @(negedge clk_b);
      n++;
    end
    if (tx_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL tx_drain: got %0d bytes pending expected 0", tx_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_cdc_data"}, CDC_data, 16'h0000);
    chk({tag, "_nr"}, nr_Rejestru, 3'd0);
    chk({tag, "_wr_rej"}, wr_Rej, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err_cmd"}, err_cmd, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, k, hold_ok;

    vecs[0]  = '{1'b1, 3'd3, 16'h002A, 16'h0000};
    vecs[1]  = '{1'b0, 3'd3, 16'h0000, 16'h002A};
    vecs[2]  = '{1'b1, 3'd4, 16'h3FFF, 16'h0000};
    vecs[3]  = '{1'b0, 3'd4, 16'h0000, 16'h3FFF};
    vecs[4]  = '{1'b1, 3'd0, 16'h0001, 16'h0000};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 16'h0001};
    vecs[6]  = '{1'b1, 3'd5, 16'h1234, 16'h0000};
    vecs[7]  = '{1'b0, 3'd5, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 3'd1, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1'b0, 3'd1, 16'h0000, DONE_VAL};
    vecs[10] = '{1'b1, 3'd0, 16'hBEEF, 16'h0000};
    vecs[11] = '{1'b0, 3'd0, 16'h0000, 16'hBEEF};

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk_b);
    rst_n = 1'b1;
    chk("rx_ready_before_edge", rx_ready, 1'b0);
    @(negedge clk_b);
    chk("rx_ready_after_edge", rx_ready, 1'b1);

    // Table: writes then reads, issued with no gaps so write->read is back-to-back.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        send_write(vecs[i].addr, vecs[i].data);
      end else begin
        send_read_cmd(vecs[i].addr, vecs[i].exp);
        drain_tx();
      end
    end
    @(negedge clk_b);
    chk("cdc_hold", CDC_data, 16'hBEEF);
    chk("nr_hold", nr_Rejestru, 3'd0);

    // Malformed command: dropped, single err pulse, next byte is a fresh read.
    send_byte(8'h48, n);
    chk("bad_cmd_err", err_cmd, 1'b1);
    chk("bad_cmd_idle", busy, 1'b0);
    @(negedge clk_b);
    chk("bad_cmd_err_single", err_cmd, 1'b0);
    send_read_cmd(3'd1, DONE_VAL);
    drain_tx();

    // Response backpressure: high byte must hold for 10 cycles.
    tx_ready = 1'b0;
    send_read_cmd(3'd2, PRACUJE_VAL);
    hold_ok = 0;
    repeat (10) begin
      if (tx_valid && tx_data == PRACUJE_VAL[15:8]) hold_ok++;
      @(negedge clk_b);
    end
    chk("bp_hold_cycles", hold_ok, 10);
    tx_ready = 1'b1;
    drain_tx();

    // Reset while the low response byte is pending.
    tx_ready = 1'b0;
    tx_q.push_back(DONE_VAL[15:8]);
    send_byte(8'h01, n);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk_b);
      k++;
    end
    tx_ready = 1'b1;
    @(negedge clk_b);
    tx_ready = 1'b0;
    chk("tx_lo_before_reset", tx_data, DONE_VAL[7:0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midframe_reset");
    chk("resp_discarded", tx_q.size(), 0);
    @(negedge clk_b);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    chk("rx_ready_rerelease", rx_ready, 1'b0);
    @(negedge clk_b);
    chk("rx_ready_resumed", rx_ready, 1'b1);

`ifdef CTRL_MASTER_TIMEOUT_EN
    // Inter-byte timeout in the write path.
    send_byte(8'h83, n);
    send_byte(8'h12, n);
    k = 0;
    while (!err_cmd && k < 64) begin
      @(negedge clk_b);
      k++;
    end
    chk("timeout_latency", k, TB_TIMEOUT);
    chk("timeout_idle", busy, 1'b0);
    send_read_cmd(3'd3, 16'h002A);
    drain_tx();
`endif

    repeat (6) @(negedge clk_b);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
